nrzi_encode: RTL

NRZI_ENCODE -- requirements
Module: nrzi_encode

---
 rtl/nrzi_encode.sv | 119 +++++++++++
 1 files changed

// File: rtl/nrzi_encode.sv
// USB NRZI line encoder with bit stuffing and EOP generation.
// The bit-rate strobe shift_enable gates every state change; all outputs are registered.
module nrzi_encode (
    input  logic clk,
    input  logic rst,
    input  logic shift_enable,
    input  logic tx_valid,
    input  logic tx_bit,
    output logic d_plus,
    output logic d_minus,
    output logic bit_taken,
    output logic stuffing,
    output logic eop_active
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        SE0_1,
        SE0_2,
        EOP_J
    } state_t;

    state_t     state_q, state_d;
    logic       lvl_q, lvl_d;
    logic [2:0] ones_q, ones_d;
    logic       bit_taken_q, bit_taken_d;
    logic       stuffing_q, stuffing_d;
    logic       d_plus_q, d_plus_d;
    logic       d_minus_q, d_minus_d;
    logic       eop_q, eop_d;

    always_comb begin
        state_d     = state_q;
        lvl_d       = lvl_q;
        ones_d      = ones_q;
        bit_taken_d = 1'b0;
        stuffing_d  = 1'b0;

        if (shift_enable) begin
            unique case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        state_d     = DATA;
                        bit_taken_d = 1'b1;
                        lvl_d       = tx_bit ? lvl_q : ~lvl_q;
                        ones_d      = tx_bit ? 3'd1 : 3'd0;
                    end else begin
                        lvl_d  = 1'b1;
                        ones_d = '0;
                    end
                end
                DATA: begin
                    // A pending stuff takes priority even when tx_valid has dropped.
                    if (ones_q == 3'd6) begin
                        stuffing_d = 1'b1;
                        lvl_d      = ~lvl_q;
                        ones_d     = '0;
                    end else if (tx_valid) begin
                        bit_taken_d = 1'b1;
                        lvl_d       = tx_bit ? lvl_q : ~lvl_q;
                        ones_d      = tx_bit ? ones_q + 3'd1 : 3'd0;
                    end else begin
                        state_d = SE0_1;
                    end
                end
                SE0_1: state_d = SE0_2;
                SE0_2: begin
                    state_d = EOP_J;
                    lvl_d   = 1'b1;
                end
                EOP_J: begin
                    state_d = IDLE;
                    lvl_d   = 1'b1;
                    ones_d  = '0;
                end
                default: begin
                    state_d = IDLE;
                    lvl_d   = 1'b1;
                    ones_d  = '0;
                end
            endcase
        end

        // Line outputs are computed from next state so they register alongside it.
        eop_d     = (state_d == SE0_1) || (state_d == SE0_2) || (state_d == EOP_J);
        d_plus_d  = ((state_d == SE0_1) || (state_d == SE0_2)) ? 1'b0 : lvl_d;
        d_minus_d = ((state_d == SE0_1) || (state_d == SE0_2)) ? 1'b0 : ~lvl_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lvl_q       <= 1'b1;
            ones_q      <= '0;
            bit_taken_q <= 1'b0;
            stuffing_q  <= 1'b0;
            d_plus_q    <= 1'b1;
            d_minus_q   <= 1'b0;
            eop_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            ones_q      <= ones_d;
            bit_taken_q <= bit_taken_d;
            stuffing_q  <= stuffing_d;
            d_plus_q    <= d_plus_d;
            d_minus_q   <= d_minus_d;
            eop_q       <= eop_d;
        end
    end

    assign d_plus     = d_plus_q;
    assign d_minus    = d_minus_q;
    assign bit_taken  = bit_taken_q;
    assign stuffing   = stuffing_q;
    assign eop_active = eop_q;

endmodule
